// File: rtl/arp_tx_generator.sv
// ARP frame transmitter: accepts one ARP request/reply descriptor per
// handshake and emits it as a 60-byte Ethernet frame over two 256-bit
// AXI-Stream beats. It also keeps per-type transmit counters.
module arp_tx_generator #(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXI_DATA_WIDTH   = 32,
  parameter int SRC_PORT_POS         = 16,
  parameter int DST_PORT_POS         = 24
) (
  input  logic                              AXI_ACLK,
  input  logic                              AXI_RESETN,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic                              req_oper,
  input  logic [7:0]                        req_dst_port,
  input  logic [47:0]                       req_src_mac,
  input  logic [31:0]                       req_src_ip,
  input  logic [47:0]                       req_tgt_mac,
  input  logic [31:0]                       req_tgt_ip,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    M_AXIS_TDATA,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  M_AXIS_TSTRB,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
  output logic                              M_AXIS_TVALID,
  input  logic                              M_AXIS_TREADY,
  output logic                              M_AXIS_TLAST,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     arp_req_count,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     arp_reply_count
);

  localparam int SW = C_M_AXIS_DATA_WIDTH / 8;
  localparam logic [C_S_AXI_DATA_WIDTH-1:0] CNT_ONE = {{(C_S_AXI_DATA_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BEAT0 = 2'd1,
    S_BEAT1 = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic        rdy_en_q;
  logic        accept;
  logic        frame_done;

  logic        oper_q;
  logic [7:0]  port_q;
  logic [47:0] src_mac_q;
  logic [31:0] src_ip_q;
  logic [47:0] tgt_mac_q;
  logic [31:0] tgt_ip_q;

  logic [C_S_AXI_DATA_WIDTH-1:0] req_cnt_q, req_cnt_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] rep_cnt_q, rep_cnt_d;

  logic [47:0]  dst_mac_w;
  logic [47:0]  arp_tmac_w;
  logic [15:0]  oper_code_w;
  logic [255:0] beat0_w;
  logic [255:0] beat1_w;
  logic [C_M_AXIS_TUSER_WIDTH-1:0] tuser_w;

  // A request broadcasts and leaves the target MAC unknown; a reply is unicast.
  assign dst_mac_w   = oper_q ? tgt_mac_q : 48'hFFFF_FFFF_FFFF;
  assign arp_tmac_w  = oper_q ? tgt_mac_q : 48'h0;
  assign oper_code_w = oper_q ? 16'h0002 : 16'h0001;

  // First byte on the wire sits in the most significant byte lane.
  assign beat0_w = {dst_mac_w, src_mac_q, 16'h0806, 16'h0001, 16'h0800,
                    8'h06, 8'h04, oper_code_w, src_mac_q, src_ip_q};
  assign beat1_w = {arp_tmac_w, tgt_ip_q, 176'h0};

  assign req_ready = (state_q == S_IDLE) && rdy_en_q;

  // Sideband: frame length, source port always zero, egress port from the request.
  always_comb begin
    tuser_w                     = '0;
    tuser_w[15:0]               = 16'd60;
    tuser_w[SRC_PORT_POS +: 8]  = 8'h00;
    tuser_w[DST_PORT_POS +: 8]  = port_q;
  end

  // Next-state and stream outputs; outputs are zero whenever no beat is offered.
  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    frame_done    = 1'b0;
    M_AXIS_TVALID = 1'b0;
    M_AXIS_TLAST  = 1'b0;
    M_AXIS_TDATA  = '0;
    M_AXIS_TSTRB  = '0;
    M_AXIS_TUSER  = '0;
    case (state_q)
      S_IDLE: begin
        if (req_valid && rdy_en_q) begin
          accept  = 1'b1;
          state_d = S_BEAT0;
        end
      end
      S_BEAT0: begin
        M_AXIS_TVALID = 1'b1;
        M_AXIS_TDATA  = beat0_w;
        M_AXIS_TSTRB  = '1;
        M_AXIS_TUSER  = tuser_w;
        if (M_AXIS_TREADY) state_d = S_BEAT1;
      end
      S_BEAT1: begin
        M_AXIS_TVALID = 1'b1;
        M_AXIS_TLAST  = 1'b1;
        M_AXIS_TDATA  = beat1_w;
        M_AXIS_TSTRB  = {{(SW-4){1'b1}}, 4'h0};
        M_AXIS_TUSER  = tuser_w;
        if (M_AXIS_TREADY) begin
          state_d    = S_IDLE;
          frame_done = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Counter next values: only a completed frame counts, by its latched type.
  always_comb begin
    req_cnt_d = req_cnt_q;
    rep_cnt_d = rep_cnt_q;
    if (frame_done) begin
      if (oper_q) rep_cnt_d = rep_cnt_q + CNT_ONE;
      else        req_cnt_d = req_cnt_q + CNT_ONE;
    end
  end

  // State, ready-enable and counters; reset abandons any frame in flight.
  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      state_q   <= S_IDLE;
      rdy_en_q  <= 1'b0;
      req_cnt_q <= '0;
      rep_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rdy_en_q  <= 1'b1;
      req_cnt_q <= req_cnt_d;
      rep_cnt_q <= rep_cnt_d;
    end
  end

  // Descriptor capture on acceptance; held untouched for the whole frame.
  always_ff @(posedge AXI_ACLK) begin
    if (accept) begin
      oper_q    <= req_oper;
      port_q    <= req_dst_port;
      src_mac_q <= req_src_mac;
      src_ip_q  <= req_src_ip;
      tgt_mac_q <= req_tgt_mac;
      tgt_ip_q  <= req_tgt_ip;
    end
  end

  assign arp_req_count   = req_cnt_q;
  assign arp_reply_count = rep_cnt_q;

endmodule

// File: tb/tb_arp_tx_generator.sv
// Scoreboard bench for arp_tx_generator: stimulus pushes expected beats,
// a negedge monitor pops and compares every accepted beat.
module tb_arp_tx_generator;

  localparam int CW = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           req_valid, req_ready, req_oper;
  logic [7:0]     req_dst_port;
  logic [47:0]    req_src_mac, req_tgt_mac;
  logic [31:0]    req_src_ip, req_tgt_ip;
  logic [255:0]   tdata;
  logic [31:0]    tstrb;
  logic [127:0]   tuser;
  logic           tvalid, tready, tlast;
  logic [CW-1:0]  req_cnt, rep_cnt;

  arp_tx_generator #(
    .C_M_AXIS_DATA_WIDTH(256), .C_M_AXIS_TUSER_WIDTH(128), .C_S_AXI_DATA_WIDTH(CW),
    .SRC_PORT_POS(16), .DST_PORT_POS(24)
  ) dut (
    .AXI_ACLK(clk), .AXI_RESETN(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_oper(req_oper),
    .req_dst_port(req_dst_port), .req_src_mac(req_src_mac), .req_src_ip(req_src_ip),
    .req_tgt_mac(req_tgt_mac), .req_tgt_ip(req_tgt_ip),
    .M_AXIS_TDATA(tdata), .M_AXIS_TSTRB(tstrb), .M_AXIS_TUSER(tuser),
    .M_AXIS_TVALID(tvalid), .M_AXIS_TREADY(tready), .M_AXIS_TLAST(tlast),
    .arp_req_count(req_cnt), .arp_reply_count(rep_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] d;
    logic [31:0]  s;
    logic [127:0] u;
    logic         l;
    logic         oper;
  } beat_t;

  beat_t   exp_q[$];
  int      gap_q[$];
  int      total = 0;
  int      bad = 0;
  int      hs_cnt = 0;
  int      idle_run = 0;
  int      tr_mode = 2;
  logic    prev_v = 1'b0;
  logic    have_prev = 1'b0;
  logic [CW-1:0] m_req = '0, m_rep = '0;
  logic [255:0]  sv_d;
  logic [31:0]   sv_s;
  logic [127:0]  sv_u;
  logic          sv_l;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [47:0] rnd48();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[47:0];
  endfunction

  // Build the 64-byte beat image from the frame layout, then slice into beats.
  function automatic void push_frame(input bit op, input logic [7:0] port,
                                     input logic [47:0] smac, input logic [31:0] sip,
                                     input logic [47:0] tmac, input logic [31:0] tip);
    logic [7:0]  fr[64];
    logic [47:0] dmac, amac;
    beat_t       b;
    for (int i = 0; i < 64; i++) fr[i] = 8'h00;
    dmac = op ? tmac : 48'hFFFF_FFFF_FFFF;
    amac = op ? tmac : 48'h0;
    for (int i = 0; i < 6; i++) begin
      fr[i]      = dmac[47-8*i -: 8];
      fr[6+i]    = smac[47-8*i -: 8];
      fr[22+i]   = smac[47-8*i -: 8];
      fr[32+i]   = amac[47-8*i -: 8];
    end
    fr[12] = 8'h08; fr[13] = 8'h06; fr[14] = 8'h00; fr[15] = 8'h01;
    fr[16] = 8'h08; fr[17] = 8'h00; fr[18] = 8'h06; fr[19] = 8'h04;
    fr[20] = 8'h00; fr[21] = op ? 8'h02 : 8'h01;
    for (int i = 0; i < 4; i++) begin
      fr[28+i] = sip[31-8*i -: 8];
      fr[38+i] = tip[31-8*i -: 8];
    end
    for (int bi = 0; bi < 2; bi++) begin
      b.d = '0; b.s = '0; b.u = '0;
      for (int k = 0; k < 32; k++) begin
        b.d[255-8*k -: 8] = fr[32*bi+k];
        b.s[31-k]         = (32*bi + k) < 60;
      end
      b.u[15:0]  = 16'd60;
      b.u[31:24] = port;
      b.l        = (bi == 1);
      b.oper     = op;
      exp_q.push_back(b);
    end
  endfunction

  // Offer one request; returns one step after the accepting edge.
  task automatic send(input bit op, input logic [7:0] port, input logic [47:0] smac,
                      input logic [31:0] sip, input logic [47:0] tmac,
                      input logic [31:0] tip, input bit hold);
    bit acc;
    req_valid = 1'b1; req_oper = op; req_dst_port = port;
    req_src_mac = smac; req_src_ip = sip; req_tgt_mac = tmac; req_tgt_ip = tip;
    acc = 1'b0;
    for (int c = 0; c < 60 && !acc; c++) begin
      @(negedge clk);
      if (req_ready) acc = 1'b1;
    end
    total++;
    if (!acc) begin
      bad++;
      $display("FAIL req_accept act=timeout exp=accepted t=%0t", $time);
    end else begin
      push_frame(op, port, smac, sip, tmac, tip);
    end
    @(posedge clk); #1;
    req_oper = 1'($urandom_range(0, 1)); req_dst_port = 8'($urandom());
    req_src_mac = rnd48(); req_src_ip = $urandom();
    req_tgt_mac = rnd48(); req_tgt_ip = $urandom();
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !tvalid) done = 1'b1;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL drain act=pending%0d exp=0 t=%0t", exp_q.size(), $time);
    end
    @(posedge clk); #1;
  endtask

  // TREADY driver: 0 = always ready, 1 = random backpressure, 2 = left to the test.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (tr_mode == 0) tready = 1'b1;
      else if (tr_mode == 1) tready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: counters, hold-stability under backpressure, and beat scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_req = '0; m_rep = '0;
      have_prev = 1'b0; prev_v = 1'b0; idle_run = 0;
    end else begin
      chk("req_count", 256'(req_cnt), 256'(m_req));
      chk("reply_count", 256'(rep_cnt), 256'(m_rep));
      if (have_prev)
        chk("hold_stable", 256'(tvalid && tdata === sv_d && tstrb === sv_s &&
                               tuser === sv_u && tlast === sv_l), 256'(1));
      if (tvalid && !prev_v) gap_q.push_back(idle_run);
      if (!tvalid) idle_run++; else idle_run = 0;
      prev_v = tvalid;
      if (tvalid && tready) begin
        hs_cnt++;
        have_prev = 1'b0;
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 256'(1), 256'(0));
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("tdata", tdata, e.d);
          chk("tstrb", 256'(tstrb), 256'(e.s));
          chk("tuser", 256'(tuser), 256'(e.u));
          chk("tlast", 256'(tlast), 256'(e.l));
          if (e.l) begin
            if (e.oper) m_rep = m_rep + 1'b1;
            else        m_req = m_req + 1'b1;
          end
        end
      end else if (tvalid) begin
        have_prev = 1'b1;
        sv_d = tdata; sv_s = tstrb; sv_u = tuser; sv_l = tlast;
      end else begin
        have_prev = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog act=running exp=finished t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int h0;
    logic [CW-1:0] base;
    int n;
    rst_n = 1'b0; req_valid = 1'b0; req_oper = 1'b0; req_dst_port = '0;
    req_src_mac = '0; req_src_ip = '0; req_tgt_mac = '0; req_tgt_ip = '0;
    tready = 1'b0;
    #3;
    chk("rst_ready", 256'(req_ready), 256'(0));
    chk("rst_tvalid", 256'(tvalid), 256'(0));
    chk("rst_tdata", tdata, 256'(0));
    chk("rst_counts", 256'({req_cnt, rep_cnt}), 256'(0));
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1 chk("ready_before_edge", 256'(req_ready), 256'(0));
    @(posedge clk); #1;
    chk("ready_after_edge", 256'(req_ready), 256'(1));
    tr_mode = 0;

    // Broadcast request
    h0 = hs_cnt;
    send(1'b0, 8'h04, 48'h00_11_22_33_44_55, 32'h0A00_0001, rnd48(), 32'h0A00_0002, 1'b0);
    drain();
    chk("req_hs", 256'(hs_cnt - h0), 256'(2));
    chk("req_cnt_1", 256'(req_cnt), 256'(1));

    // Unicast reply
    send(1'b1, 8'h10, 48'h00_11_22_33_44_55, 32'h0A00_0001, 48'hAA_BB_CC_DD_EE_FF,
         32'h0A00_0002, 1'b0);
    drain();
    chk("rep_cnt_1", 256'(rep_cnt), 256'(1));
    chk("req_cnt_kept", 256'(req_cnt), 256'(1));

    // Backpressure: 5 stalled cycles on each beat
    tr_mode = 2; tready = 1'b0;
    h0 = hs_cnt;
    send(1'b0, 8'h01, rnd48(), $urandom(), rnd48(), $urandom(), 1'b0);
    repeat (5) @(posedge clk);
    #1 tready = 1'b1;
    @(posedge clk); #1 tready = 1'b0;
    repeat (5) @(posedge clk);
    #1 tready = 1'b1;
    @(posedge clk); #1 tready = 1'b0;
    tr_mode = 0;
    drain();
    chk("stall_hs", 256'(hs_cnt - h0), 256'(2));
    chk("stall_cnt", 256'(req_cnt), 256'(2));

    // Back-to-back with req_valid held high
    gap_q.delete();
    base = req_cnt;
    for (int i = 0; i < 3; i++)
      send(1'b0, 8'(1 << i), rnd48(), $urandom(), rnd48(), $urandom(), i < 2);
    drain();
    chk("b2b_frames", 256'(gap_q.size()), 256'(3));
    if (gap_q.size() == 3) begin
      chk("b2b_gap1", 256'(gap_q[1]), 256'(1));
      chk("b2b_gap2", 256'(gap_q[2]), 256'(1));
    end
    chk("b2b_cnt", 256'(req_cnt), 256'(base + 8'd3));

    // Reset after the first beat is accepted
    tr_mode = 2; tready = 1'b0;
    send(1'b1, 8'h80, rnd48(), $urandom(), rnd48(), $urandom(), 1'b0);
    tready = 1'b1;
    @(posedge clk); #1 tready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_tvalid", 256'({tvalid, tlast}), 256'(0));
    chk("mid_rst_tdata", tdata, 256'(0));
    chk("mid_rst_side", 256'({tstrb, tuser}), 256'(0));
    chk("mid_rst_counts", 256'({req_cnt, rep_cnt}), 256'(0));
    chk("mid_rst_ready", 256'(req_ready), 256'(0));
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    tr_mode = 0;
    send(1'b1, 8'h02, rnd48(), $urandom(), rnd48(), $urandom(), 1'b0);
    drain();
    chk("post_rst_counts", 256'({req_cnt, rep_cnt}), 256'({8'd0, 8'd1}));

    // Randomized traffic with random backpressure
    tr_mode = 1;
    for (int i = 0; i < 40; i++)
      send(1'($urandom_range(0, 1)), 8'(1 << $urandom_range(0, 7)), rnd48(), $urandom(),
           rnd48(), $urandom(), 1'($urandom_range(0, 1)));
    req_valid = 1'b0;
    drain();

    // Counter wrap
    tr_mode = 0;
    n = 255 - int'(m_req);
    for (int i = 0; i < n; i++)
      send(1'b0, 8'h08, rnd48(), $urandom(), rnd48(), $urandom(), 1'b0);
    drain();
    chk("pre_wrap", 256'(req_cnt), 256'(8'hFF));
    send(1'b0, 8'h08, rnd48(), $urandom(), rnd48(), $urandom(), 1'b0);
    drain();
    chk("wrap", 256'(req_cnt), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
